// File: rtl/rr_mux_n_to_1_if.sv
// Handshake bundle between N producers, the round-robin merger and one consumer.
// slave  : the merger's view (consumes in_*, drives out_*).
// master : the surrounding environment's view (drives in_*, consumes out_*).
interface rr_mux_n_to_1_if #(
    parameter int N = 8,
    parameter int W = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_src,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_src,
        output out_ready
    );
endinterface

// File: rtl/rr_mux_n_to_1.sv
// Registered N-to-1 round-robin merger. Each output word carries the index of the
// channel it came from, encoded like the matching demux select.
//
// state | meaning
// EMPTY | output register holds nothing (out_valid=0)
// FULL  | output register holds a word waiting for the consumer (out_valid=1)
module rr_mux_n_to_1 #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_mux_n_to_1_if.slave  bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_src;
    logic [SW-1:0] r_ptr;

    logic          w_load_en;
    logic          w_any_req;
    logic [SW-1:0] w_grant;
    logic [W-1:0]  w_grant_data;
    logic [N-1:0]  w_ready;
    logic [SW-1:0] w_ptr_nxt;

    // Output register can take a new word when empty or when being drained this cycle.
    assign w_load_en = (r_state == EMPTY) || bus.out_ready;
    assign w_any_req = |bus.in_valid;

    // Scan channels starting at the pointer, wrapping at N; first requester wins.
    always_comb begin
        int   idx;
        logic found;
        idx          = 0;
        found        = 1'b0;
        w_grant      = '0;
        w_grant_data = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && bus.in_valid[idx]) begin
                found        = 1'b1;
                w_grant      = SW'(idx);
                w_grant_data = bus.in_data[idx*W +: W];
            end
        end
    end

    // Pointer moves to the channel after the winner; explicit wrap keeps it below N.
    assign w_ptr_nxt = (w_grant == SW'(N - 1)) ? '0 : w_grant + SW'(1);

    // One-hot accept toward the winning producer only.
    always_comb begin
        w_ready = '0;
        if (w_load_en && w_any_req) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    // Next state: fill on a grant, empty on a drain with no new request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_any_req) w_state_nxt = FULL;
            FULL:  if (bus.out_ready) w_state_nxt = w_any_req ? FULL : EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the granted word and advance the pointer only when a grant happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_src  <= '0;
            r_ptr  <= '0;
        end else if (w_load_en && w_any_req) begin
            r_data <= w_grant_data;
            r_src  <= w_grant;
            r_ptr  <= w_ptr_nxt;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = (r_state == FULL);
    assign bus.out_data  = r_data;
    assign bus.out_src   = r_src;
endmodule

// File: tb/tb_rr_mux_n_to_1.sv
// Bench for the round-robin merger: directed scenarios plus a randomized run,
// checked against a behavioural model of the arbitration rules.
module tb_rr_mux_n_to_1;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int N5 = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_mux_n_to_1_if #(.N(N),  .W(W)) bus8();
    rr_mux_n_to_1_if #(.N(N5), .W(W)) bus5();

    rr_mux_n_to_1 #(.N(N),  .W(W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    rr_mux_n_to_1 #(.N(N5), .W(W)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

    int compared   = 0;
    int mismatched = 0;

    // Stimulus for the N=8 instance.
    logic [N-1:0] v8;
    logic [W-1:0] d8 [N];
    logic         ordy;

    // Reference model: held word and round-robin start position.
    int m_v, m_d, m_s, m_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive8();
        bus8.in_valid  = v8;
        for (int i = 0; i < N; i++) bus8.in_data[i*W +: W] = d8[i];
        bus8.out_ready = ordy;
    endtask

    // One clock of the N=8 instance, entered and left at a falling edge.
    task automatic tick8();
        int           g;
        bit           any, le;
        logic [N-1:0] er;
        drive8();
        #1;
        le  = (m_v == 0) || ordy;
        any = 1'b0;
        g   = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!any && v8[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
        er = '0;
        if (le && any) er[g] = 1'b1;
        chk("in_ready", bus8.in_ready, er);
        @(posedge clk);
        #1;
        if (le) begin
            if (any) begin
                m_v   = 1;
                m_d   = d8[g];
                m_s   = g;
                m_ptr = (g + 1) % N;
                v8[g] = 1'b0;
            end else begin
                m_v = 0;
            end
        end
        chk("out_valid", bus8.out_valid, m_v);
        chk("out_data",  bus8.out_data,  m_d);
        chk("out_src",   bus8.out_src,   m_s);
        chk("src_range", (bus8.out_src < N), 1);
        @(negedge clk);
    endtask

    // Asynchronous reset taken between edges; outputs must clear before any clock.
    task automatic do_reset();
        #2;
        v8 = '0;
        ordy = 1'b0;
        drive8();
        bus5.in_valid  = '0;
        bus5.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid",  bus8.out_valid, 0);
        chk("rst_out_src",    bus8.out_src,   0);
        chk("rst_out_data",   bus8.out_data,  0);
        chk("rst_in_ready",   bus8.in_ready,  0);
        chk("rst5_out_valid", bus5.out_valid, 0);
        m_v = 0; m_d = 0; m_s = 0; m_ptr = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic all_valid(input int base);
        for (int i = 0; i < N; i++) begin
            if (!v8[i]) begin
                v8[i] = 1'b1;
                d8[i] = W'(base + i * 17);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        v8 = '0;
        ordy = 1'b0;
        for (int i = 0; i < N; i++) d8[i] = '0;
        drive8();
        bus5.in_valid  = '0;
        bus5.in_data   = '0;
        bus5.out_ready = 1'b0;
        @(negedge clk);

        // Reset with no requests.
        do_reset();

        // Single request on channel 5.
        v8[5] = 1'b1;
        d8[5] = 8'hA5;
        ordy  = 1'b1;
        tick8();
        chk("ch5_src", bus8.out_src, 5);
        chk("ch5_data", bus8.out_data, 8'hA5);

        // All channels requesting: grants rotate 0..7 then wrap.
        do_reset();
        ordy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            all_valid(i * 8);
            tick8();
            chk("rotate_src", bus8.out_src, i % N);
        end

        // Backpressure: held word stays, nobody is accepted, then drain and load together.
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            all_valid(100);
            tick8();
            chk("stall_src", bus8.out_src, 1);
        end
        ordy = 1'b1;
        tick8();
        chk("drain_load_src", bus8.out_src, 2);
        chk("drain_load_valid", bus8.out_valid, 1);

        // N=5 wrap: move the pointer to 4, then channels 4 and 0 compete.
        bus5.out_ready = 1'b1;
        bus5.in_data   = {8'h44, 8'h00, 8'h33, 8'h00, 8'h10};
        bus5.in_valid  = 5'b01000;
        #1;
        chk("n5_ready_ch3", bus5.in_ready, 5'b01000);
        @(posedge clk); #1;
        chk("n5_src_3", bus5.out_src, 3);
        @(negedge clk);
        bus5.in_valid = 5'b10001;
        #1;
        chk("n5_ready_ch4", bus5.in_ready, 5'b10000);
        @(posedge clk); #1;
        chk("n5_src_4", bus5.out_src, 4);
        chk("n5_data_4", bus5.out_data, 8'h44);
        @(negedge clk);
        bus5.in_valid = 5'b00001;
        #1;
        chk("n5_ready_ch0", bus5.in_ready, 5'b00001);
        @(posedge clk); #1;
        chk("n5_src_0", bus5.out_src, 0);
        chk("n5_data_0", bus5.out_data, 8'h10);
        @(negedge clk);
        bus5.in_valid = '0;
        @(posedge clk); #1;
        chk("n5_drained", bus5.out_valid, 0);
        @(negedge clk);

        // Reset while FULL and stalled; first grant afterwards starts at channel 0.
        v8 = '0;
        v8[3] = 1'b1;
        d8[3] = 8'h3C;
        ordy = 1'b1;
        tick8();
        ordy = 1'b0;
        tick8();
        chk("pre_rst_full", bus8.out_valid, 1);
        do_reset();
        ordy = 1'b1;
        all_valid(8'h60);
        tick8();
        chk("post_rst_src", bus8.out_src, 0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v8[i] && $urandom_range(0, 2) == 0) begin
                    v8[i] = 1'b1;
                    d8[i] = W'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            tick8();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
